// File: rtl/corePckg.sv
// Shared core types: datapath width and the fetch-control bundle driven back to fetch.
package corePckg;
  localparam int unsigned cXLEN = 32;

  typedef struct packed {
    logic             noOp;
    logic             newPcValid;
    logic [cXLEN-1:0] newPc;
  } tFetchCtrl;
endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-to-decode control: pairs RAM data with its PC, steers fetch on boot/redirect/JAL,
// and buffers decode backpressure with an output register plus a 1-entry skid buffer.
module fetch_ctrl
  import corePckg::*;
#(
  parameter logic [cXLEN-1:0] cResetPc = 32'h0000_0000
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [cXLEN-1:0] iCurPc,
  input  logic [cXLEN-1:0] iInstr,
  input  logic             iStall,
  input  logic             iExRedirect,
  input  logic [cXLEN-1:0] iExTarget,
  output tFetchCtrl        oFetchCtrl,
  output logic             oValid,
  output logic [cXLEN-1:0] oInstr,
  output logic [cXLEN-1:0] oPc
);

  localparam logic [6:0] cOpJal = 7'b1101111;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [cXLEN-1:0] pcd_q, pcd_d;
  logic             adv_q, adv_d;
  logic             out_vld_q, out_vld_d;
  logic [cXLEN-1:0] out_instr_q, out_instr_d;
  logic [cXLEN-1:0] out_pc_q, out_pc_d;
  logic             skid_vld_q, skid_vld_d;
  logic [cXLEN-1:0] skid_instr_q, skid_instr_d;
  logic [cXLEN-1:0] skid_pc_q, skid_pc_d;

  logic             accept;
  logic             is_jal;
  logic [20:0]      jal_imm;
  logic [cXLEN-1:0] jal_tgt;
  tFetchCtrl        fc;

  // Data is only trusted if fetch actually stepped sequentially on the previous cycle.
  assign accept  = adv_q & ~iExRedirect;
  assign is_jal  = accept && (iInstr[6:0] == cOpJal);
  assign jal_imm = {iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};
  assign jal_tgt = pcd_q + {{(cXLEN-21){jal_imm[20]}}, jal_imm};

  always_comb begin
    fc = '0;
    if (iRst || state_q == BOOT) begin
      fc.newPcValid = 1'b1;
      fc.newPc      = cResetPc;
    end else if (iExRedirect) begin
      fc.newPcValid = 1'b1;
      fc.newPc      = iExTarget;
    end else if (is_jal) begin
      fc.newPcValid = 1'b1;
      fc.newPc      = jal_tgt;
    end
    fc.noOp = iStall & ~fc.newPcValid;
  end

  assign oFetchCtrl = fc;

  always_comb begin
    pcd_d = iCurPc;
    adv_d = (state_q != BOOT) && !fc.noOp && !fc.newPcValid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (iStall && accept && out_vld_q) state_d = HOLD;
      HOLD:    if (!iStall || iExRedirect) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (iExRedirect) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!iStall) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        skid_vld_d  = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_instr_d = iInstr;
          out_pc_d    = pcd_q;
        end
      end
    end else if (accept) begin
      // Decode is holding: park behind a valid output, otherwise fill the empty slot.
      if (out_vld_q) begin
        skid_vld_d   = 1'b1;
        skid_instr_d = iInstr;
        skid_pc_d    = pcd_q;
      end else begin
        out_vld_d   = 1'b1;
        out_instr_d = iInstr;
        out_pc_d    = pcd_q;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= BOOT;
      pcd_q        <= '0;
      adv_q        <= 1'b0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pcd_q        <= pcd_d;
      adv_q        <= adv_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign oValid = out_vld_q;
  assign oInstr = out_instr_q;
  assign oPc    = out_pc_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL take parameter cResetPc, default 32'h0000_0000: the PC driven to fetch during reset and boot.
REQ-002 SHALL take cXLEN (32) and the tFetchCtrl struct {noOp, newPcValid, newPc[cXLEN-1:0]} from corePckg.
REQ-003 iClk  in  1  core clock; all state updates on its rising edge.
REQ-004 iRst  in  1  synchronous, active-high reset.
REQ-005 iCurPc  in  cXLEN  fetch current PC (address presented to the instruction RAM this cycle).
REQ-006 iInstr  in  cXLEN  fetch RAM read data, one cycle after its address.
REQ-007 iStall  in  1  decode backpressure; 1 = output stage must hold.
REQ-008 iExRedirect  in  1  execute-stage redirect (taken branch, JALR, mispredict).
REQ-009 iExTarget  in  cXLEN  redirect target, qualified by iExRedirect.
REQ-010 oFetchCtrl  out  tFetchCtrl  control to fetch, combinational from state and inputs.
REQ-011 oValid  out  1  registered; oInstr/oPc hold a valid instruction.
REQ-012 oInstr  out  cXLEN  registered instruction to decode.
REQ-013 oPc  out  cXLEN  registered PC of oInstr.

Function
REQ-014 SHALL register pcD <= iCurPc every cycle; iInstr in cycle t pairs with pcD (iCurPc of t-1).
REQ-015 SHALL register advD = 1 in cycle t iff in cycle t-1 state != BOOT, iRst = 0, oFetchCtrl.noOp = 0 and oFetchCtrl.newPcValid = 0.
REQ-016 An arriving instruction is accepted in cycle t iff advD = 1 and iExRedirect = 0; all others are dropped.
REQ-017 FSM states: BOOT, RUN, HOLD.
- Reset enters BOOT.
- BOOT goes to RUN unconditionally.
- RUN goes to HOLD when iStall = 1, an instruction is accepted and oValid = 1.
- HOLD goes to RUN when iStall = 0 or iExRedirect = 1.
REQ-018 oFetchCtrl priority, highest first:
- iRst or BOOT: newPcValid = 1, newPc = cResetPc.
- iExRedirect: newPcValid = 1, newPc = iExTarget.
- Accepted JAL: newPcValid = 1, newPc = jalTarget.
- Otherwise: newPcValid = 0, newPc = 0.
REQ-019 noOp = iStall AND NOT newPcValid, so a redirect is never masked by a stall.
REQ-020 JAL detection: opcode iInstr[6:0] = 7'b1101111 on an accepted instruction.
REQ-021 jalTarget = pcD + sext({iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0}), truncated to cXLEN bits (wrap modulo 2^cXLEN).
REQ-022 An accepted JAL itself SHALL still be delivered to decode; only younger instructions are dropped (one bubble).
REQ-023 Output register loading when iStall = 0:
- If the skid buffer is valid: load oInstr/oPc from the skid buffer, set oValid = 1, clear the skid buffer.
- Else: load the accepted instruction with oValid = 1, or oValid = 0 if none is accepted.
REQ-024 Output register when iStall = 1:
- oValid/oInstr/oPc hold.
- An accepted instruction goes to the 1-entry skid buffer if oValid = 1.
- An accepted instruction goes directly to the output register if oValid = 0.
REQ-025 Skid buffer valid while an accepted instruction arrives SHALL not occur; bench asserts it never happens.
REQ-026 iExRedirect = 1 SHALL, on that edge:
- Clear oValid and the skid buffer.
- Drop the arriving instruction.
- Return to RUN.
- Execute target wins over a simultaneous JAL.
REQ-027 No instruction SHALL be delivered twice or lost; oPc of consecutive oValid beats differs by 4 unless a redirect intervened.
REQ-028 Latency: accepted in cycle t gives oValid in cycle t+1; redirect in cycle t gives the first target instruction on oValid in cycle t+3.

Reset
REQ-029 While iRst = 1:
- oValid = 0, oInstr = 0, oPc = 0.
- Skid buffer cleared, advD = 0, pcD = 0, state = BOOT.
- oFetchCtrl = {noOp 0, newPcValid 1, newPc cResetPc}.
REQ-030 Reset asserted mid-operation (HOLD, pending redirect) SHALL discard all state within the same edge, identical to power-on reset.
REQ-031 Counting the first cycle with iRst = 0 as cycle 0: cycle 0 is BOOT; the first oValid appears in cycle 3 with oPc = cResetPc.

Verification
REQ-032 Boot: cResetPc = 0x80, linear NOPs (0x00000013), no stall -> oValid first high in cycle 3, oPc = 0x80, then 0x84, 0x88 on consecutive cycles.
REQ-033 Stall: iStall high 3 cycles mid-stream at oPc = 0x8 -> oPc holds 0x8, noOp = 1, then oPc = 0xC, 0x10 with no gap, loss or duplicate.
REQ-034 JAL: JAL at 0x8 with imm = +0x100 -> newPcValid pulse, newPc = 0x108; 0x8 delivered; 0xC never valid; next valid oPc = 0x108.
REQ-035 Backward JAL at 0x0 with imm = -4 -> newPc = 0xFFFF_FFFC (wrap).
REQ-036 Conflict: iExRedirect (iExTarget = 0x200) in the same cycle as an accepted JAL during a stall -> newPc = 0x200, noOp = 0, oValid = 0 next cycle, next valid oPc = 0x200.
REQ-037 Reset in HOLD: iRst pulse while the skid buffer is full -> oValid = 0 next cycle, skid instruction never delivered, boot sequence per REQ-031.
